// File: rtl/lbi_pkg.sv
// lbi_pkg: shared state encoding, mode constants and clog2 helper for the LBI row accumulator.
package lbi_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam logic MODE_COUNT  = 1'b0;
   localparam logic MODE_PARITY = 1'b1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/lbi_popcnt.sv
// lbi_popcnt: combinational population count of a W-bit word.
module lbi_popcnt import lbi_pkg::*; #(
   parameter int W  = 16,
   parameter int OW = clog2(W + 1)
) (
   input  logic [W-1:0]  d_i,
   output logic [OW-1:0] cnt_o
);
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) cnt_o = cnt_o + OW'(d_i[i]);
   end
endmodule

// File: rtl/lbi_row_acc.sv
// lbi_row_acc: multi-channel chunked popcount(msg & key) accumulator with count/parity result
// returned over a valid/ready handshake.
module lbi_row_acc import lbi_pkg::*; #(
   parameter int VEC_W   = 840,
   parameter int CHUNK_W = 16,
   parameter int NUM_CH  = 2,
   parameter int SUM_W   = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH*VEC_W-1:0]   msg_in,
   input  logic                      msg_vld,
   output logic                      msg_rdy,
   input  logic [VEC_W-1:0]          key_in,
   input  logic                      mode,
   input  logic                      start,
   output logic                      start_rdy,
   output logic [NUM_CH*SUM_W-1:0]   res_out,
   output logic                      res_vld,
   input  logic                      res_rdy
);
   localparam int NCHUNK = (VEC_W + CHUNK_W - 1) / CHUNK_W;
   localparam int PW     = NCHUNK * CHUNK_W;
   localparam int CNT_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
   localparam int OFF_W  = (PW > 1) ? clog2(PW) : 1;
   localparam int PC_W   = clog2(CHUNK_W + 1);

   if (SUM_W < clog2(VEC_W + 1)) begin : g_sum_w_chk
      $error("lbi_row_acc: SUM_W too small to hold a full-row popcount");
   end

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [NUM_CH-1:0][PW-1:0]     msg_q, msg_d;
   logic [PW-1:0]                 key_q, key_d;
   logic                          mode_q, mode_d, last_q, last_d;
   logic [NUM_CH-1:0][SUM_W-1:0]  sum_q, sum_d, res_q, res_d;
   logic [NUM_CH-1:0][PC_W-1:0]   pc, pc_q, pc_d;
   logic [OFF_W-1:0]              off;

   assign off = OFF_W'(cnt_q * CHUNK_W);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      lbi_popcnt #(.W(CHUNK_W), .OW(PC_W)) u_pc (
         .d_i   (msg_q[c][off +: CHUNK_W] & key_q[off +: CHUNK_W]),
         .cnt_o (pc[c])
      );
   end

   // Popcounts are registered before accumulation, so the last chunk lands one edge after cnt tops out.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      msg_d   = msg_q;
      key_d   = key_q;
      mode_d  = mode_q;
      last_d  = last_q;
      sum_d   = sum_q;
      pc_d    = pc_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (msg_vld) for (int c = 0; c < NUM_CH; c++) msg_d[c] = PW'(msg_in[c*VEC_W +: VEC_W]);
            if (start) begin
               key_d   = PW'(key_in);
               mode_d  = mode;
               cnt_d   = '0;
               last_d  = 1'b0;
               sum_d   = '0;
               pc_d    = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            pc_d = pc;
            for (int c = 0; c < NUM_CH; c++) sum_d[c] = sum_q[c] + SUM_W'(pc_q[c]);
            last_d = cnt_q == CNT_W'(NCHUNK - 1);
            cnt_d  = last_d ? cnt_q : cnt_q + 1'b1;
            if (last_q) begin
               state_d = DONE;
               for (int c = 0; c < NUM_CH; c++)
                  res_d[c] = (mode_q == MODE_PARITY) ? SUM_W'(sum_d[c][0]) : sum_d[c];
            end
         end
         DONE: state_d = res_rdy ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         msg_q   <= '0;
         key_q   <= '0;
         mode_q  <= 1'b0;
         last_q  <= 1'b0;
         sum_q   <= '0;
         pc_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         key_q   <= key_d;
         mode_q  <= mode_d;
         last_q  <= last_d;
         sum_q   <= sum_d;
         pc_q    <= pc_d;
         res_q   <= res_d;
      end
   end

   assign msg_rdy   = state_q == IDLE;
   assign start_rdy = state_q == IDLE;
   assign res_vld   = state_q == DONE;
   assign res_out   = res_q;
endmodule

// File: tb/tb_lbi_row_acc.sv
// tb_lbi_row_acc: randomized scoreboard bench for lbi_row_acc (default and small-width instances).
module tb_lbi_row_acc;
   localparam int VW = 840, NC = 2, SW = 10, NCH = 53;
   localparam int SVW = 20, SSW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic [NC*VW-1:0]    msg_in;
   logic                msg_vld, msg_rdy, mode, start, start_rdy, res_vld, res_rdy;
   logic [VW-1:0]       key_in;
   logic [NC*SW-1:0]    res_out;
   logic [NC*SVW-1:0]   s_msg_in;
   logic                s_msg_vld, s_msg_rdy, s_mode, s_start, s_start_rdy, s_res_vld, s_res_rdy;
   logic [SVW-1:0]      s_key_in;
   logic [NC*SSW-1:0]   s_res_out;

   lbi_row_acc dut (
      .clk(clk), .reset(reset), .msg_in(msg_in), .msg_vld(msg_vld), .msg_rdy(msg_rdy),
      .key_in(key_in), .mode(mode), .start(start), .start_rdy(start_rdy),
      .res_out(res_out), .res_vld(res_vld), .res_rdy(res_rdy)
   );

   lbi_row_acc #(.VEC_W(SVW), .CHUNK_W(8), .NUM_CH(NC), .SUM_W(SSW)) dut_s (
      .clk(clk), .reset(reset), .msg_in(s_msg_in), .msg_vld(s_msg_vld), .msg_rdy(s_msg_rdy),
      .key_in(s_key_in), .mode(s_mode), .start(s_start), .start_rdy(s_start_rdy),
      .res_out(s_res_out), .res_vld(s_res_vld), .res_rdy(s_res_rdy)
   );

   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic [NC*SW-1:0] exp_q[$];
   int               st_q[$];
   logic [NC*VW-1:0] mdl_msg;
   bit               seen = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [NC*SW-1:0] model(input logic [NC*VW-1:0] m, input logic [VW-1:0] k, input logic md);
      logic [NC*SW-1:0] r;
      r = '0;
      for (int c = 0; c < NC; c++) begin
         int s;
         s = $countones(m[c*VW +: VW] & k);
         r[c*SW +: SW] = SW'(md ? s % 2 : s);
      end
      return r;
   endfunction

   function automatic logic [NC*SSW-1:0] s_model(input logic [NC*SVW-1:0] m, input logic [SVW-1:0] k, input logic md);
      logic [NC*SSW-1:0] r;
      r = '0;
      for (int c = 0; c < NC; c++) begin
         int s;
         s = $countones(m[c*SVW +: SVW] & k);
         r[c*SSW +: SSW] = SSW'(md ? s % 2 : s);
      end
      return r;
   endfunction

   function automatic logic [NC*VW-1:0] rnd_msg();
      logic [NC*VW-1:0] r;
      for (int i = 0; i < NC*VW; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && start && start_rdy) st_q.push_back(cyc);
   end

   // Scoreboard monitor: each new result is compared against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!res_vld) seen = 1'b0;
      else if (!seen) begin
         seen = 1'b1;
         if (exp_q.size() == 0 || st_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %0h with no row outstanding", res_out);
         end else begin
            chk("res_out", res_out, exp_q.pop_front());
            chk("latency", cyc - st_q.pop_front() - 1, NCH + 1);
         end
      end
   end

   task automatic begin_row(input logic [NC*VW-1:0] m, input bit ld, input logic [VW-1:0] k, input logic md);
      msg_in = m; msg_vld = ld; key_in = k; mode = md; start = 1'b1;
      if (ld) mdl_msg = m;
      exp_q.push_back(model(mdl_msg, k, md));
      @(posedge clk); #1;
      start = 1'b0; msg_vld = 1'b0;
   endtask

   task automatic wait_vld();
      int n;
      n = 0;
      while (!res_vld && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!res_vld) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_vld: res_vld=0 after %0d cycles, required 1", n);
      end
   endtask

   task automatic finish_row(input int hold);
      repeat (hold) @(negedge clk);
      res_rdy = 1'b1;
      @(posedge clk); #1;
      res_rdy = 1'b0;
      chk("vld_after_hs", res_vld, 0);
      chk("start_rdy_after_hs", start_rdy, 1);
   endtask

   task automatic run(input logic [NC*VW-1:0] m, input bit ld, input logic [VW-1:0] k, input logic md, input int hold);
      begin_row(m, ld, k, md);
      wait_vld();
      finish_row(hold);
   endtask

   task automatic s_run(input logic [NC*SVW-1:0] m, input logic [SVW-1:0] k, input logic md);
      int lat;
      s_msg_in = m; s_msg_vld = 1'b1; s_key_in = k; s_mode = md; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0; s_msg_vld = 1'b0;
      lat = 0;
      while (!s_res_vld && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("s_latency", lat, 4);
      chk("s_res_out", s_res_out, s_model(m, k, md));
      s_res_rdy = 1'b1;
      @(posedge clk); #1;
      s_res_rdy = 1'b0;
   endtask

   initial begin
      logic [NC*VW-1:0] m;
      logic [NC*SW-1:0] held;
      reset = 1'b1; msg_in = '0; msg_vld = 1'b0; key_in = '0; mode = 1'b0; start = 1'b0; res_rdy = 1'b0;
      s_msg_in = '0; s_msg_vld = 1'b0; s_key_in = '0; s_mode = 1'b0; s_start = 1'b0; s_res_rdy = 1'b0;
      mdl_msg = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_res_vld", res_vld, 0);
      chk("rst_res_out", res_out, 0);
      chk("rst_msg_rdy", msg_rdy, 1);
      chk("rst_start_rdy", start_rdy, 1);
      @(posedge clk); #1;

      run('1, 1'b1, '1, 1'b0, 0);
      m = '0;
      m[VW-1:0] = '1;
      run(m, 1'b1, VW'(7), 1'b1, 0);
      run(m, 1'b0, VW'(7), 1'b0, 2);

      // Backpressure: result must hold while start/msg_vld are pulsed and ignored.
      begin_row(rnd_msg(), 1'b1, VW'(rnd_msg()), 1'($urandom_range(0, 1)));
      wait_vld();
      held = res_out;
      repeat (10) begin
         @(posedge clk); #1;
         start = 1'b1; msg_vld = 1'b1; msg_in = rnd_msg();
         @(negedge clk);
         chk("hold_res_out", res_out, held);
         chk("hold_start_rdy", start_rdy, 0);
         chk("hold_msg_rdy", msg_rdy, 0);
      end
      start = 1'b0; msg_vld = 1'b0;
      finish_row(0);
      chk("hs_msg_rdy", msg_rdy, 1);
      run(rnd_msg(), 1'b0, '1, 1'b0, 0);

      // Reset at the 20th RUN cycle discards the row and clears message registers.
      begin_row(rnd_msg(), 1'b1, '1, 1'b0);
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      st_q.delete();
      mdl_msg = '0;
      chk("mid_rst_res_vld", res_vld, 0);
      chk("mid_rst_res_out", res_out, 0);
      chk("mid_rst_msg_rdy", msg_rdy, 1);
      chk("mid_rst_start_rdy", start_rdy, 1);
      run(rnd_msg(), 1'b0, '1, 1'b0, 0);
      m = '0;
      m[3:0] = 4'hF;
      run(m, 1'b1, '1, 1'b0, 0);
      m = '0;
      m[7:0] = 8'hFF;
      run(m, 1'b1, '1, 1'b0, 1);

      repeat (6) run(rnd_msg(), 1'($urandom_range(0, 1)), VW'(rnd_msg()), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: %0d expected results never seen, required 0", exp_q.size());
      end

      s_run('1, '1, 1'b0);
      repeat (3) s_run(NC*SVW'($urandom), SVW'($urandom), 1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
